acq_write_ctrl: RTL and testbench
=================================

Name: acq_write_ctrl

Overview:
- Capture controller directly upstream of the dual-port sample RAM.
- Once armed, it waits for a trigger edge, then writes a programmable number of ADC samples into consecutive RAM addresses starting at 0, and flags completion.
- The readout side (USB/SPI) consumes the RAM after `done`.
- Single clock domain: ADC and RAM write port share `clk`.

Parameters:
- ADDR_W, 13, RAM address width; maximum capture depth is 2**ADDR_W samples.
- DATA_W, 16, RAM word width.
- SMP_W, 10, ADC sample width; must be ≤ DATA_W-6.

Ports:
- clk  in  1  system clock; also the RAM write clock.
- rst  in  1  synchronous reset, active-high.
- arm  in  1  single-cycle pulse; starts a new acquisition.
- abort  in  1  single-cycle pulse; cancels any acquisition.
- trig  in  1  trigger level, already synchronous to clk.
- len  in  ADDR_W  sample count; 0 means 2**ADDR_W.
- smp_data  in  SMP_W  ADC sample.
- smp_valid  in  1  sample qualifier.
- ram_wdata  out  DATA_W  RAM write data.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_wr  out  1  RAM write enable.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- wr_cnt  out  ADDR_W+1  number of samples written in the current/last acquisition.

Behaviour:
- All outputs are registered. On reset: state=IDLE and every output is 0; trig_q=0, arm counter=0.
- Trigger edge detect: `trig_q` registers `trig`. A rising edge is `trig & ~trig_q` and is evaluated only in ARMED.
- State machine IDLE, ARMED, CAPTURE, DONE:
  - IDLE: `arm` → ARMED. At that edge, `wr_cnt` clears to 0, `len` is latched (0 → 2**ADDR_W), and `done` falls.
  - DONE: same transition as IDLE. `done` stays high until `arm`, `abort` or `rst`.
  - ARMED: a trig rising edge at cycle t → CAPTURE at t+1. Samples valid at cycle t itself are not stored.
  - CAPTURE: each cycle with `smp_valid`=1 produces, on the next cycle:
    - `ram_wr`=1,
    - `ram_waddr` = current write count (starting at 0),
    - `ram_wdata` = sample in the low SMP_W bits.
  - `ram_wr` is a one-cycle pulse per sample, with no gaps added. `wr_cnt` increments together with each `ram_wr` pulse.
  - When the accepted sample count reaches the latched length, state → DONE and `done`=1 in the same cycle as the final `ram_wr` pulse. Further `smp_valid` is ignored.
- Priority: rst > abort > arm > trig/smp_valid.
- `abort` in any state → IDLE next cycle. A pending write still completes (one cycle). `done` clears. `wr_cnt` holds its value for debug.
- `arm` while ARMED or CAPTURE is ignored. Re-arming requires abort or DONE.
- `trig` already high when entering ARMED does not fire; a fresh rising edge is required.
- Address never wraps within an acquisition. The maximum count 2**ADDR_W ends at address 2**ADDR_W-1, with `wr_cnt` = 2**ADDR_W.
- Reset mid-capture: IDLE, outputs 0, no further writes. RAM contents are undefined to readout.

Optional Feature:
- Macro `ACQ_TAG_EN`.
- Defined:
  - `ram_wdata[DATA_W-1]` = 1 on the first sample of an acquisition, else 0.
  - `ram_wdata[DATA_W-2:DATA_W-6]` = 5 LSBs of an acquisition counter. The counter increments on each accepted `arm` and wraps 31→0.
  - Remaining unused bits are 0.
- Not defined: all bits above SMP_W are 0, and the acquisition counter is not implemented.

Test Plan:
- Reset, then arm; after 2 cycles, trig rises; smp_valid continuous with data 0x001, 0x002, …; len=4 → four `ram_wr` pulses at addresses 0..3 with data 0x001..0x004, `done`=1 on the 4th pulse, `wr_cnt`=4, `busy`=0.
- Gapped valid: smp_valid pattern 1,0,0,1,1; len=3 → writes at addresses 0,1,2 only on cycles following valid; no write on gap cycles.
- trig held high before and during arm, len=2 → no capture until trig falls and rises again; then 2 writes.
- Abort after 5 of len=10 samples → state IDLE, no further `ram_wr`, `done`=0, `wr_cnt`=5; a new arm clears `wr_cnt` to 0.
- len=0 with ADDR_W=4 → exactly 16 writes at addresses 0..15, `wr_cnt`=16, no address wrap; arm during CAPTURE ignored.
- With `ACQ_TAG_EN`: three consecutive acquisitions, sample 0x3FF → first word of each = 0x83FF, 0x87FF, 0x8BFF; later words in each acquisition have bit15=0.

Source files
------------

// File: rtl/acq_write_ctrl_if.sv
// Capture-controller bus: trigger/sample inputs, RAM write port and status outputs.
// The master side drives control and samples; the slave side is the controller.
interface acq_write_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int SMP_W  = 10
) ();
  logic              arm;
  logic              abort;
  logic              trig;
  logic [ADDR_W-1:0] len;
  logic [SMP_W-1:0]  smp_data;
  logic              smp_valid;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_wr;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_cnt;

  modport master (
    output arm, abort, trig, len, smp_data, smp_valid,
    input  ram_wdata, ram_waddr, ram_wr, busy, done, wr_cnt
  );

  modport slave (
    input  arm, abort, trig, len, smp_data, smp_valid,
    output ram_wdata, ram_waddr, ram_wr, busy, done, wr_cnt
  );
endinterface

// File: rtl/acq_write_ctrl.sv
// Armed, trigger-started capture of ADC samples into consecutive RAM addresses.
// Optional macro ACQ_TAG_EN adds a first-sample flag and acquisition tag in the upper data bits.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for arm; outputs hold last acquisition's counters
// ARMED   | waiting for a fresh trig rising edge
// CAPTURE | storing each valid sample until the latched length is met
// DONE    | acquisition complete, RAM ready for readout
module acq_write_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter int SMP_W  = 10
) (
  input logic          clk,
  input logic          rst,
  acq_write_ctrl_if.slave bus
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(1) << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              trig_q;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  len_lat_q, len_lat_d;
  logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_wr_q, ram_wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef ACQ_TAG_EN
  logic [4:0]        acq_cnt_q, acq_cnt_d;
  logic [4:0]        tag_q, tag_d;
`endif

  logic              trig_rise;
  logic              arm_ok;
  logic              smp_take;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] smp_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      trig_q      <= 1'b0;
      wr_cnt_q    <= '0;
      len_lat_q   <= '0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      ram_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ACQ_TAG_EN
      acq_cnt_q   <= '0;
      tag_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      trig_q      <= bus.trig;
      wr_cnt_q    <= wr_cnt_d;
      len_lat_q   <= len_lat_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wr_q    <= ram_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ACQ_TAG_EN
      acq_cnt_q   <= acq_cnt_d;
      tag_q       <= tag_d;
`endif
    end
  end

  // abort outranks arm, which outranks trigger and sample activity
  always_comb begin
    trig_rise = bus.trig & ~trig_q;
    arm_ok    = bus.arm & ~bus.abort & ((state_q == S_IDLE) | (state_q == S_DONE));
    smp_take  = ~bus.abort & (state_q == S_CAPTURE) & bus.smp_valid;
    cnt_inc   = wr_cnt_q + CNT_ONE;
    state_d   = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (bus.arm) state_d = S_ARMED;
        S_ARMED:        if (trig_rise) state_d = S_CAPTURE;
        S_CAPTURE:      if (smp_take && (cnt_inc == len_lat_q)) state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    smp_word = '0;
    smp_word[SMP_W-1:0] = bus.smp_data;
`ifdef ACQ_TAG_EN
    smp_word[DATA_W-1]          = (wr_cnt_q == '0);
    smp_word[DATA_W-2:DATA_W-6] = tag_q;
    acq_cnt_d = acq_cnt_q;
    tag_d     = tag_q;
`endif
    wr_cnt_d    = wr_cnt_q;
    len_lat_d   = len_lat_q;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wr_d    = 1'b0;
    if (arm_ok) begin
      wr_cnt_d  = '0;
      len_lat_d = (bus.len == '0) ? FULL_LEN : {1'b0, bus.len};
`ifdef ACQ_TAG_EN
      tag_d     = acq_cnt_q;
      acq_cnt_d = acq_cnt_q + 5'd1;
`endif
    end else if (smp_take) begin
      ram_wr_d    = 1'b1;
      ram_waddr_d = wr_cnt_q[ADDR_W-1:0];
      ram_wdata_d = smp_word;
      wr_cnt_d    = cnt_inc;
    end
    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_waddr = ram_waddr_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wr_cnt    = wr_cnt_q;
endmodule

// File: tb/tb_acq_write_ctrl.sv
// Directed bench for acq_write_ctrl with a write scoreboard; tag model follows ACQ_TAG_EN.
module tb_acq_write_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int SW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   n_wr = 0;
  logic [4:0] acq_next = '0;
  logic [4:0] acq_tag  = '0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  acq_write_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .SMP_W(SW)) bus ();

  acq_write_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SMP_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] addr, input logic [SW-1:0] smp);
    logic [31:0] w;
    w = 32'(smp);
`ifdef ACQ_TAG_EN
    if (addr == 0) w[DW-1] = 1'b1;
    w[DW-2 -: 5] = acq_tag;
`endif
    return w;
  endfunction

  task automatic push(input int addr, input logic [SW-1:0] smp);
    exp_addr.push_back(32'(addr));
    exp_data.push_back(exp_word(32'(addr), smp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [AW-1:0] l);
    bus.len = l;
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
    acq_tag  = acq_next;
    acq_next = acq_next + 5'd1;
  endtask

  // Every write pulse is matched against the oldest expected write
  always @(negedge clk) begin
    if (bus.ram_wr === 1'b1) begin
      n_wr++;
      if (exp_addr.size() == 0) begin
        check("unexpected_wr", 32'(bus.ram_waddr), 32'hFFFF_FFFF);
      end else begin
        check("wr_addr", 32'(bus.ram_waddr), exp_addr.pop_front());
        check("wr_data", 32'(bus.ram_wdata), exp_data.pop_front());
      end
    end
  end

  initial begin
    logic [4:0] pat;
    int wa;
    int nw0;
    bus.arm = 0; bus.abort = 0; bus.trig = 0; bus.len = '0;
    bus.smp_data = '0; bus.smp_valid = 0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_done",  32'(bus.done), 0);
    check("rst_wr",    32'(bus.ram_wr), 0);
    check("rst_wrcnt", 32'(bus.wr_cnt), 0);
    check("rst_waddr", 32'(bus.ram_waddr), 0);
    check("rst_wdata", 32'(bus.ram_wdata), 0);

    // basic capture, len=4, trigger-cycle sample discarded
    do_arm(4'd4);
    check("t1_busy_armed", 32'(bus.busy), 1);
    repeat (2) step();
    bus.trig = 1; bus.smp_valid = 1; bus.smp_data = 10'h3AA;
    step();
    for (int i = 1; i <= 6; i++) begin
      bus.smp_data = SW'(i);
      if (i <= 4) push(i - 1, SW'(i));
      step();
      if (i == 4) begin
        check("t1_done",  32'(bus.done), 1);
        check("t1_wrcnt", 32'(bus.wr_cnt), 4);
        check("t1_busy",  32'(bus.busy), 0);
        check("t1_wr",    32'(bus.ram_wr), 1);
      end
    end
    check("t1_done_hold", 32'(bus.done), 1);
    check("t1_sb_empty", 32'(exp_addr.size()), 0);
    bus.trig = 0; bus.smp_valid = 0;
    step();

    // gapped valid pattern, len=3
    do_arm(4'd3);
    check("t2_done_cleared", 32'(bus.done), 0);
    bus.trig = 1;
    step();
    pat = 5'b11001;
    wa = 0;
    for (int k = 0; k < 5; k++) begin
      bus.smp_valid = pat[k];
      bus.smp_data  = SW'(16 + k);
      if (pat[k]) begin push(wa, SW'(16 + k)); wa++; end
      step();
      check("t2_wr_pattern", 32'(bus.ram_wr), 32'(pat[k]));
    end
    check("t2_done",  32'(bus.done), 1);
    check("t2_wrcnt", 32'(bus.wr_cnt), 3);
    bus.smp_valid = 0;

    // trig already high at arm must not fire
    do_arm(4'd2);
    nw0 = n_wr;
    bus.smp_valid = 1; bus.smp_data = 10'h055;
    repeat (3) step();
    check("t3_busy_wait", 32'(bus.busy), 1);
    check("t3_no_wr", 32'(n_wr - nw0), 0);
    bus.trig = 0;
    step();
    bus.trig = 1;
    step();
    push(0, 10'h021); push(1, 10'h022);
    bus.smp_data = 10'h021; step();
    bus.smp_data = 10'h022; step();
    check("t3_done",  32'(bus.done), 1);
    check("t3_wrcnt", 32'(bus.wr_cnt), 2);
    bus.smp_valid = 0; bus.trig = 0;
    step();

    // abort after 5 of 10
    do_arm(4'd10);
    bus.trig = 1;
    step();
    for (int k = 0; k < 5; k++) begin
      bus.smp_valid = 1; bus.smp_data = SW'(48 + k);
      push(k, SW'(48 + k));
      step();
    end
    bus.abort = 1; bus.smp_data = 10'h035;
    step();
    bus.abort = 0;
    check("t4_busy",  32'(bus.busy), 0);
    check("t4_done",  32'(bus.done), 0);
    check("t4_wr",    32'(bus.ram_wr), 0);
    check("t4_wrcnt", 32'(bus.wr_cnt), 5);
    nw0 = n_wr;
    repeat (3) step();
    check("t4_no_wr", 32'(n_wr - nw0), 0);
    check("t4_wrcnt_hold", 32'(bus.wr_cnt), 5);
    bus.smp_valid = 0; bus.trig = 0;
    do_arm(4'd10);
    check("t4_rearm_wrcnt", 32'(bus.wr_cnt), 0);
    bus.abort = 1; step(); bus.abort = 0;
    check("t4_abort_armed", 32'(bus.busy), 0);

    // len=0 means full depth; arm during capture ignored
    do_arm(4'd0);
    bus.trig = 1;
    step();
    for (int i = 0; i < 20; i++) begin
      bus.smp_valid = 1; bus.smp_data = SW'(64 + i);
      if (i < 16) push(i, SW'(64 + i));
      bus.arm = (i == 5);
      step();
      bus.arm = 0;
      if (i == 15) begin
        check("t5_done",  32'(bus.done), 1);
        check("t5_wrcnt", 32'(bus.wr_cnt), 16);
        check("t5_waddr", 32'(bus.ram_waddr), 15);
      end
    end
    bus.smp_valid = 0;
    step();
    check("t5_wrcnt_final", 32'(bus.wr_cnt), 16);
    check("t5_sb_empty", 32'(exp_addr.size()), 0);

    // reset mid-capture
    bus.trig = 0; step();
    do_arm(4'd5);
    bus.trig = 1; step();
    push(0, 10'h060); push(1, 10'h061);
    bus.smp_valid = 1;
    bus.smp_data = 10'h060; step();
    bus.smp_data = 10'h061; step();
    rst = 1; bus.smp_data = 10'h062;
    step();
    check("rst_mid_wr",    32'(bus.ram_wr), 0);
    check("rst_mid_busy",  32'(bus.busy), 0);
    check("rst_mid_wrcnt", 32'(bus.wr_cnt), 0);
    check("rst_mid_wdata", 32'(bus.ram_wdata), 0);
    rst = 0; bus.smp_valid = 0; bus.trig = 0;
    acq_next = '0;
    nw0 = n_wr;
    step();
    check("rst_mid_no_wr", 32'(n_wr - nw0), 0);

    // three back-to-back acquisitions of 0x3FF
    for (int a = 0; a < 3; a++) begin
      bus.trig = 0; step();
      do_arm(4'd2);
      bus.trig = 1; step();
      push(0, 10'h3FF); push(1, 10'h3FF);
      bus.smp_valid = 1; bus.smp_data = 10'h3FF;
      step(); step();
      bus.smp_valid = 0;
      check("t6_done", 32'(bus.done), 1);
    end
    step();
    check("final_sb_empty", 32'(exp_addr.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
